// File: rtl/writeback_unit.sv
// Writeback buffer: merges ALU and load results into an in-order FIFO and drains
// one entry per cycle to the register-file write port unless held.
module writeback_unit #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alu_valid,
    input  logic [2:0]              alu_rd,
    input  logic [15:0]             alu_data,
    output logic                    alu_ready,
    input  logic                    mem_valid,
    input  logic [2:0]              mem_rd,
    input  logic [15:0]             mem_data,
    output logic                    mem_ready,
    input  logic                    hold,
    output logic                    reg_write,
    output logic [2:0]              write_reg,
    output logic [15:0]             write_data,
    output logic [7:0]              busy_regs,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [2:0]    rd_mem   [DEPTH];
    logic [15:0]   data_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] alu_slot;
    logic [CW-1:0] free;
    logic          push_mem;
    logic          push_alu;
    logic          pop;

    // Free space comes from the registered count only, so a pop in the same
    // cycle never lets an extra push in; the load gets the last slot.
    assign free      = CW'(DEPTH) - count;
    assign mem_ready = (free >= CW'(1));
    assign alu_ready = (free >= CW'(2)) || ((free == CW'(1)) && !mem_valid);

    assign push_mem  = mem_valid && mem_ready;
    assign push_alu  = alu_valid && alu_ready;
    assign alu_slot  = wr_ptr + AW'(push_mem);

    assign reg_write  = (count != '0) && !hold;
    assign pop        = reg_write;
    assign write_reg  = rd_mem[rd_ptr];
    assign write_data = data_mem[rd_ptr];

    // An entry is occupied when its distance from the head is below count.
    always_comb begin
        // NOTE: default every always_comb output first so no latch is inferred.
        busy_regs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, AW'(i) - rd_ptr} < count) begin
                busy_regs[rd_mem[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            rd_ptr <= rd_ptr + AW'(pop);
            wr_ptr <= wr_ptr + AW'(push_mem) + AW'(push_alu);
            count  <= count + CW'(push_mem) + CW'(push_alu) - CW'(pop);
        end
    end

    // NOTE: storage has no reset; occupancy is defined by pointers and count.
    always_ff @(posedge clk) begin
        if (push_mem) begin
            rd_mem[wr_ptr]   <= mem_rd;
            data_mem[wr_ptr] <= mem_data;
        end
        if (push_alu) begin
            rd_mem[alu_slot]   <= alu_rd;
            data_mem[alu_slot] <= alu_data;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: a queue models the FIFO, readiness,
// busy registers and the order of register-file writes.
module tb_writeback_unit;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [2:0]  rd;
        logic [15:0] data;
    } entry_t;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [2:0]  alu_rd;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [2:0]  mem_rd;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        hold;
    logic        reg_write;
    logic [2:0]  write_reg;
    logic [15:0] write_data;
    logic [7:0]  busy_regs;
    logic [$clog2(DEPTH):0] count;

    entry_t      sb_q[$];
    int          n_checks;
    int          n_errors;
    logic [15:0] last_wdata;

    writeback_unit #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .mem_valid  (mem_valid),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .hold       (hold),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .busy_regs  (busy_regs),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input logic av, input logic [2:0] ard, input logic [15:0] adat,
                         input logic mv, input logic [2:0] mrd, input logic [15:0] mdat,
                         input logic h, output logic acc_a, output logic acc_m);
        int         free;
        logic       exp_mr;
        logic       exp_ar;
        logic       exp_we;
        logic [7:0] exp_busy;
        alu_valid = av;  alu_rd = ard;  alu_data = adat;
        mem_valid = mv;  mem_rd = mrd;  mem_data = mdat;
        hold = h;
        #1;
        free     = DEPTH - sb_q.size();
        exp_mr   = (free >= 1);
        exp_ar   = (free >= 2) || (free == 1 && !mv);
        exp_we   = (sb_q.size() != 0) && !h;
        exp_busy = '0;
        foreach (sb_q[i]) exp_busy[sb_q[i].rd] = 1'b1;
        check("count", 32'(count), 32'(sb_q.size()));
        check("mem_ready", 32'(mem_ready), 32'(exp_mr));
        check("alu_ready", 32'(alu_ready), 32'(exp_ar));
        check("busy_regs", 32'(busy_regs), 32'(exp_busy));
        check("reg_write", 32'(reg_write), 32'(exp_we));
        if (exp_we) begin
            check("write_reg", 32'(write_reg), 32'(sb_q[0].rd));
            check("write_data", 32'(write_data), 32'(sb_q[0].data));
            last_wdata = write_data;
        end
        acc_m = mv && exp_mr;
        acc_a = av && exp_ar;
        @(posedge clk);
        if (exp_we) void'(sb_q.pop_front());
        if (acc_m) sb_q.push_back('{rd: mrd, data: mdat});
        if (acc_a) sb_q.push_back('{rd: ard, data: adat});
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic h);
        logic aa, am;
        for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, h, aa, am);
    endtask

    task automatic push_alu(input logic [2:0] rd, input logic [15:0] data, input logic h);
        logic aa, am;
        cycle(1'b1, rd, data, 1'b0, 3'd0, 16'h0, h, aa, am);
        check("push_alu_acc", 32'(aa), 32'd1);
    endtask

    initial begin
        logic aa, am;
        logic       pa, pm;
        logic [2:0] pa_rd, pm_rd;
        logic [15:0] pa_d, pm_d;
        n_checks = 0;
        n_errors = 0;
        last_wdata = '0;
        reset = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        hold = 1'b0;

        // Reset values
        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_reg_write", 32'(reg_write), 32'd0);
        check("rst_busy", 32'(busy_regs), 32'd0);
        check("rst_alu_ready", 32'(alu_ready), 32'd1);
        check("rst_mem_ready", 32'(mem_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;

        // Single ALU result, one-cycle latency to the write port
        push_alu(3'd3, 16'hABCD, 1'b0);
        check("lat_busy", 32'(busy_regs), 32'h08);
        idle(2, 1'b0);

        // Both offers in one cycle: load first
        cycle(1'b1, 3'd2, 16'h0022, 1'b1, 3'd1, 16'h0011, 1'b0, aa, am);
        check("both_acc_a", 32'(aa), 32'd1);
        check("both_acc_m", 32'(am), 32'd1);
        idle(3, 1'b0);

        // Fill under hold, then drain in order
        for (int i = 0; i < 4; i++) push_alu(3'(4 + i), 16'(16'h1000 + i), 1'b1);
        idle(2, 1'b1);
        idle(5, 1'b0);

        // Last slot goes to the load; ALU waits for the first pop
        for (int i = 0; i < 3; i++) push_alu(3'(i), 16'(16'h2000 + i), 1'b1);
        cycle(1'b1, 3'd6, 16'h2AAA, 1'b1, 3'd7, 16'h2BBB, 1'b1, aa, am);
        check("last_slot_mem", 32'(am), 32'd1);
        check("last_slot_alu", 32'(aa), 32'd0);
        cycle(1'b1, 3'd6, 16'h2AAA, 1'b0, 3'd0, 16'h0, 1'b0, aa, am);
        check("full_alu_wait", 32'(aa), 32'd0);
        cycle(1'b1, 3'd6, 16'h2AAA, 1'b0, 3'd0, 16'h0, 1'b0, aa, am);
        check("alu_after_pop", 32'(aa), 32'd1);
        idle(6, 1'b0);

        // Duplicate destination: youngest value written last
        push_alu(3'd5, 16'h0001, 1'b1);
        push_alu(3'd5, 16'h0002, 1'b1);
        idle(4, 1'b0);
        check("dup_final", 32'(last_wdata), 32'h0002);

        // Randomised traffic with stable held offers (exercises pointer wrap)
        pa = 1'b0; pm = 1'b0; pa_rd = '0; pm_rd = '0; pa_d = '0; pm_d = '0;
        for (int i = 0; i < 300; i++) begin
            if (!pa) begin
                pa = ($urandom_range(0, 2) != 0);
                pa_rd = 3'($urandom_range(0, 7));
                pa_d = 16'($urandom);
            end
            if (!pm) begin
                pm = ($urandom_range(0, 2) == 0);
                pm_rd = 3'($urandom_range(0, 7));
                pm_d = 16'($urandom);
            end
            cycle(pa, pa_rd, pa_d, pm, pm_rd, pm_d, ($urandom_range(0, 3) == 0), aa, am);
            if (aa) pa = 1'b0;
            if (am) pm = 1'b0;
        end
        idle(6, 1'b0);

        // Reset mid-operation discards buffered entries
        for (int i = 0; i < 3; i++) push_alu(3'(i + 1), 16'(16'h3000 + i), 1'b1);
        hold = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_reg_write", 32'(reg_write), 32'd0);
        check("mid_rst_busy", 32'(busy_regs), 32'd0);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b1;
        idle(3, 1'b0);
        push_alu(3'd0, 16'h00FF, 1'b0);
        idle(2, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
